modulation_config_ctrl: RTL

- Shadow-register controller for the modulation sampler's configuration (CYCLE, FREQ_DIV).
- Accepts update requests from the host/config decoder through a valid/ready handshake and validates them.
- Applies a valid update either immediately or at the sampler's next wrap to index 0, then holds BUSY while the sampler's divider pipeline refills with the new values.
- Drives the sampler's CYCLE/FREQ_DIV inputs directly.

---
 rtl/modulation_ctrl_pkg.sv | 17 +
 rtl/modulation_config_ctrl.sv | 131 +++++++++++++
 2 files changed

// File: rtl/modulation_ctrl_pkg.sv
// modulation_ctrl_pkg: shared types and default constants for the modulation sampler configuration.
// Holds the controller state enum plus reset/limit defaults that the sampler
// instantiation and the host register map also reference.
package modulation_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_WRAP,
        ST_SETTLE
    } state_e;

    localparam logic [15:0] RESET_CYCLE_DEF    = 16'd3999;
    localparam logic [31:0] RESET_FREQ_DIV_DEF = 32'd40960;
    localparam logic [31:0] MIN_FREQ_DIV_DEF   = 32'd1160;
    localparam int unsigned SETTLE_CYCLES_DEF  = 80;

endpackage

// File: rtl/modulation_config_ctrl.sv
// modulation_config_ctrl: shadow-register controller for the sampler's CYCLE/FREQ_DIV.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   req_valid_i/req_ready_o  update request handshake (ready only in IDLE)
//   req_cycle_i              requested modulation length minus one
//   req_freq_div_i           requested sampling divider
//   req_immediate_i          1 = apply now, 0 = apply at next wrap to index 0
//   start_i, idx_i           sampler new-index pulse and current index
//   cycle_o, freq_div_o      active configuration driven to the sampler
//   applied_o                one-cycle pulse when new values go live
//   err_o                    one-cycle pulse on rejected request or wrap timeout
//   busy_o                   sampler output untrustworthy while its pipeline refills
module modulation_config_ctrl
    import modulation_ctrl_pkg::*;
#(
    parameter logic [31:0] MIN_FREQ_DIV   = MIN_FREQ_DIV_DEF,
    parameter logic [15:0] RESET_CYCLE    = RESET_CYCLE_DEF,
    parameter logic [31:0] RESET_FREQ_DIV = RESET_FREQ_DIV_DEF,
    parameter int unsigned SETTLE_CYCLES  = SETTLE_CYCLES_DEF,
    parameter logic [31:0] WRAP_TIMEOUT   = 32'hFFFF_FFFF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [15:0] req_cycle_i,
    input  logic [31:0] req_freq_div_i,
    input  logic        req_immediate_i,
    input  logic        start_i,
    input  logic [15:0] idx_i,
    output logic [15:0] cycle_o,
    output logic [31:0] freq_div_o,
    output logic        applied_o,
    output logic        err_o,
    output logic        busy_o
);

    localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [31:0] TMO_LAST    = WRAP_TIMEOUT - 32'd1;

    state_e      state_q;
    logic [15:0] cycle_q, shadow_cycle_q;
    logic [31:0] freq_div_q, shadow_freq_div_q;
    logic [31:0] tmo_q;
    logic [7:0]  settle_q;
    logic        ready_q, applied_q, err_q, busy_q;
    logic        wrap;
    logic        req_ok;

    assign wrap   = start_i && (idx_i == 16'd0);
    assign req_ok = req_freq_div_i >= MIN_FREQ_DIV;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q           <= ST_SETTLE;
            cycle_q           <= RESET_CYCLE;
            freq_div_q        <= RESET_FREQ_DIV;
            shadow_cycle_q    <= RESET_CYCLE;
            shadow_freq_div_q <= RESET_FREQ_DIV;
            tmo_q             <= '0;
            settle_q          <= '0;
            ready_q           <= 1'b0;
            applied_q         <= 1'b0;
            err_q             <= 1'b0;
            busy_q            <= 1'b1;
        end else begin
            applied_q <= 1'b0;
            err_q     <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        shadow_cycle_q    <= req_cycle_i;
                        shadow_freq_div_q <= req_freq_div_i;
                        if (!req_ok) begin
                            err_q <= 1'b1;
                        end else if (req_immediate_i) begin
                            // Bypass the shadow so the new values are live one cycle after the handshake.
                            cycle_q    <= req_cycle_i;
                            freq_div_q <= req_freq_div_i;
                            applied_q  <= 1'b1;
                            busy_q     <= 1'b1;
                            ready_q    <= 1'b0;
                            settle_q   <= '0;
                            state_q    <= ST_SETTLE;
                        end else begin
                            tmo_q   <= '0;
                            ready_q <= 1'b0;
                            state_q <= ST_WAIT_WRAP;
                        end
                    end
                end
                ST_WAIT_WRAP: begin
                    // A wrap landing on the timeout cycle still counts as a clean apply.
                    if (wrap || tmo_q == TMO_LAST) begin
                        cycle_q    <= shadow_cycle_q;
                        freq_div_q <= shadow_freq_div_q;
                        applied_q  <= 1'b1;
                        err_q      <= !wrap;
                        busy_q     <= 1'b1;
                        settle_q   <= '0;
                        state_q    <= ST_SETTLE;
                    end else begin
                        tmo_q <= tmo_q + 32'd1;
                    end
                end
                ST_SETTLE: begin
                    if (settle_q == SETTLE_LAST) begin
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        settle_q <= settle_q + 8'd1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready_o = ready_q;
    assign cycle_o     = cycle_q;
    assign freq_div_o  = freq_div_q;
    assign applied_o   = applied_q;
    assign err_o       = err_q;
    assign busy_o      = busy_q;

endmodule
